// File: rtl/pll_reset_pkg.sv
// ---------------------------------------------------------------------------
// pll_reset_pkg
// Shared types and helpers for the PLL reset sequencer.
//   prs_state_t  : sequencer state; the encoding is visible on state_o
//   PRS_STATE_W  : width of the state encoding
//   max_int      : elaboration-time max, used to size the shared counter
// ---------------------------------------------------------------------------
package pll_reset_pkg;

    localparam int PRS_STATE_W = 2;

    typedef enum logic [PRS_STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } prs_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// N-flop synchronizer for a single asynchronous bit.
// Generic enough for any single-bit clock-domain crossing.
// Parameters:
//   STAGES     number of flops in the chain (>= 2)
//   RESET_VAL  value loaded into every flop while reset is high
// Ports:
//   clock  in   destination clock
//   reset  in   asynchronous, active-high
//   d      in   asynchronous input bit
//   q      out  synchronized bit, STAGES clock edges behind d
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // d enters at bit 0 and reaches the top bit after STAGES edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_reset_seq
// Reset sequencer in the PLL output clock domain. Holds the downstream reset
// until the PLL lock flag has been stably high for a qualification window
// plus a hold-off period, and re-asserts it as soon as lock is lost.
// Optional feature macro: PLL_RESET_LOSS_CNT_EN
//   defined   : loss_count counts RUN->WAIT_LOCK transitions, saturating
//   undefined : no counter flops, loss_count is tied to zero
// Ports:
//   clock       in   PLL output clock, rising edge
//   reset       in   asynchronous, active-high
//   locked      in   PLL lock flag, asynchronous to clock
//   rst_out     out  active-high reset for the PLL clock domain (registered)
//   ready       out  high only in RUN, always ~rst_out (registered)
//   state_o     out  current state encoding
//   loss_count  out  saturating lock-loss event count
// ---------------------------------------------------------------------------
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int LOSS_CNT_W    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   locked,
    output logic                   rst_out,
    output logic                   ready,
    output logic [PRS_STATE_W-1:0] state_o,
    output logic [LOSS_CNT_W-1:0]  loss_count
);

    // One counter serves both FILTER and HOLD, so it is sized for the longer.
    localparam int CNT_W = $clog2(max_int(FILTER_CYCLES, HOLD_CYCLES)) + 1;

    logic             lock_s;
    prs_state_t       state;
    logic [CNT_W-1:0] cnt;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d     (locked),
        .q     (lock_s)
    );

    // Loss of lock is checked before the terminal count in every state, so a
    // drop on the same cycle as the terminal count always wins. rst_out and
    // ready only change on entering or leaving RUN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rst_out <= 1'b1;
            ready   <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= FILTER;
                        cnt   <= '0;
                    end
                end
                FILTER: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(FILTER_CYCLES - 1)) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        state   <= RUN;
                        cnt     <= '0;
                        rst_out <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        rst_out <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    cnt     <= '0;
                    rst_out <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

`ifdef PLL_RESET_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_q;

    // Only losses out of RUN are counted; drops during qualification are not.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loss_q <= '0;
        end else if ((state == RUN) && !lock_s && (loss_q != '1)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign loss_count = loss_q;
`else
    assign loss_count = '0;
`endif

endmodule
